lfsr_source: RTL

Pseudo-random operand generator feeding the b input of the downstream unsigned magnitude comparator (a > b).
- Produces a WIDTH-bit XNOR-feedback LFSR value that advances once every DIV clock cycles while running.
- Supports a seed-load path and a freeze (hold) path.
- Flags a valid operand and a one-cycle step pulse on each update, so consumers sample the comparator only on fresh values.

---
 rtl/lfsr_pkg.sv | 35 +++
 rtl/lfsr_prescaler.sv | 31 +++
 rtl/lfsr_source.sv | 133 +++++++++++++
 3 files changed

// File: rtl/lfsr_pkg.sv
// Shared types and constants for the lfsr_source operand generator:
// FSM state encoding, per-width XNOR tap masks and the lockup pattern.
package lfsr_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } state_t;

    localparam int MAX_WIDTH = 12;

    // Tap n maps to bit n-1 of the mask.
    localparam logic [MAX_WIDTH-1:0] TAPS_W8  = 12'h0B8;  // taps 8,6,5,4
    localparam logic [MAX_WIDTH-1:0] TAPS_W9  = 12'h110;  // taps 9,5
    localparam logic [MAX_WIDTH-1:0] TAPS_W10 = 12'h240;  // taps 10,7
    localparam logic [MAX_WIDTH-1:0] TAPS_W12 = 12'h829;  // taps 12,6,4,1

    localparam logic [MAX_WIDTH-1:0] LOCKUP = '1;

    function automatic logic [MAX_WIDTH-1:0] tap_mask(input int width);
        case (width)
            8:       return TAPS_W8;
            9:       return TAPS_W9;
            10:      return TAPS_W10;
            12:      return TAPS_W12;
            default: return '0;
        endcase
    endfunction

    function automatic logic width_supported(input int width);
        return (width == 8) || (width == 9) || (width == 10) || (width == 12);
    endfunction

endpackage

// File: rtl/lfsr_prescaler.sv
// Divide-by-DIV step prescaler: synchronous clear, freezes when count_en is low,
// tc is high in the enabled cycle that completes a DIV-cycle interval.
module lfsr_prescaler #(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic count_en,
    output logic tc
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] count;

    // NOTE: registers are written with non-blocking assignments so every reader in the same edge sees the pre-edge value.
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (count_en) begin
            count <= (count == LAST) ? '0 : count + 1'b1;
        end
    end

    assign tc = count_en && (count == LAST);

endmodule

// File: rtl/lfsr_source.sv
// XNOR-feedback LFSR operand source with prescaled stepping, seed load and hold.
// Optional full-period wrap flag is built only when LFSR_WRAP_FLAG_EN is defined.
module lfsr_source
    import lfsr_pkg::*;
#(
    parameter int WIDTH = 10,
    parameter int DIV   = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             stop,
    input  logic             hold,
    input  logic             load,
    input  logic [WIDTH-1:0] seed,
    output logic [WIDTH-1:0] value,
    output logic             valid,
    output logic             step,
    output logic             wrap
);

    if (!width_supported(WIDTH)) begin : g_bad_width
        $error("lfsr_source: WIDTH must be 8, 9, 10 or 12");
    end
    if (DIV < 1) begin : g_bad_div
        $error("lfsr_source: DIV must be >= 1");
    end

    localparam logic [WIDTH-1:0] TAPS = WIDTH'(tap_mask(WIDTH));
    localparam logic [WIDTH-1:0] LOCK = WIDTH'(LOCKUP);

    state_t           state, state_next;
    logic             start_run;
    logic             run_en;
    logic             presc_clear;
    logic             advance;
    logic             fb;
    logic [WIDTH-1:0] lfsr_next;
    logic [WIDTH-1:0] seed_safe;

    assign fb        = ~(^(value & TAPS));
    assign lfsr_next = {value[WIDTH-2:0], fb};
    // An all-ones seed would lock an XNOR LFSR, so it is replaced by zero.
    assign seed_safe = (seed == LOCK) ? '0 : seed;

    // Load keeps the state unchanged except that a coincident stop still applies.
    always_comb begin
        state_next = state;
        start_run  = 1'b0;
        case (state)
            IDLE: begin
                if (start && !stop && !load) begin
                    state_next = RUN;
                    start_run  = 1'b1;
                end
            end
            RUN: begin
                if (stop)
                    state_next = IDLE;
                else if (hold && !load)
                    state_next = HOLD;
            end
            HOLD: begin
                if (stop)
                    state_next = IDLE;
                else if (!hold && !load)
                    state_next = RUN;
            end
            default: state_next = IDLE;
        endcase
    end

    assign run_en      = (state == RUN) && !stop && !load;
    assign presc_clear = load || start_run || (stop && (state != IDLE));

    lfsr_prescaler #(.DIV(DIV)) u_prescaler (
        .clk      (clk),
        .reset    (reset),
        .clear    (presc_clear),
        .count_en (run_en),
        .tc       (advance)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            value <= '0;
            step  <= 1'b0;
        end else begin
            state <= state_next;
            step  <= advance;
            if (load)
                value <= seed_safe;
            else if (advance)
                value <= lfsr_next;
        end
    end

    assign valid = (state != IDLE);

`ifdef LFSR_WRAP_FLAG_EN
    localparam logic [WIDTH-1:0] LAST_STEP = WIDTH'((1 << WIDTH) - 2);

    logic [WIDTH-1:0] ref_value;
    logic [WIDTH-1:0] step_cnt;
    logic             wrap_hit;

    // The advance that completes a full period lands back on the captured value.
    assign wrap_hit = advance && (step_cnt == LAST_STEP) && (lfsr_next == ref_value);

    always_ff @(posedge clk) begin
        if (reset) begin
            ref_value <= '0;
            step_cnt  <= '0;
            wrap      <= 1'b0;
        end else begin
            wrap <= wrap_hit;
            if (load) begin
                ref_value <= seed_safe;
                step_cnt  <= '0;
            end else if (start_run) begin
                ref_value <= value;
                step_cnt  <= '0;
            end else if (advance) begin
                step_cnt <= wrap_hit ? '0 : step_cnt + 1'b1;
            end
        end
    end
`else
    assign wrap = 1'b0;
`endif

endmodule
